uart_rx_byte: RTL and testbench

Serial-to-parallel UART receiver, 8N1 (optionally 8E1), sitting directly upstream of the UART control stage. Oversamples the asynchronous `rxd` pin with the system clock, validates start/stop (and optional parity) bits, and delivers each byte as `rx_data` plus a one-cycle `rx_ready` strobe. The control stage counts received bytes on `rx_ready` and latches `rx_data`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_byte_if.sv | 24 ++
 rtl/uart_rx_byte_sync_2ff.sv | 31 +++
 rtl/uart_rx_byte.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame constants and baud divisor helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side signal bundle: serial pin in, byte/strobes/status out.
// Strobes (rx_ready, rx_frame_err, rx_parity_err) are single-cycle pulses with no back-pressure;
// rx_data is valid on the cycle rx_ready is high and is held until the next good frame.
interface uart_rx_byte_if;

  logic                     rxd;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     rx_frame_err;
  logic                     rx_parity_err;
  logic                     rx_busy;
  uart_pkg::uart_rx_state_t rx_state;

  modport master (
    input  rxd,
    output rx_data, rx_ready, rx_frame_err, rx_parity_err, rx_busy, rx_state
  );

  modport slave (
    output rxd,
    input  rx_data, rx_ready, rx_frame_err, rx_parity_err, rx_busy, rx_state
  );

endinterface

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; RESET_VAL sets the level both flops take in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling UART byte receiver, 8N1 by default; defining UART_RX_PARITY_EN adds an
// even-parity bit (8E1). Samples mid-bit, delivers rx_data with one-cycle status strobes.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input logic            clk,
  input logic            rst,
  uart_rx_byte_if.master rx_if
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rxs;

  sync_2ff #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_if.rxd),
    .q   (rxs)
  );

  uart_rx_state_t            state_q,   state_d;
  logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [UART_DATA_BITS-1:0] data_q,    data_d;
  logic                      ready_q,   ready_d;
  logic                      ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      perr_q,    perr_d;
`endif
  logic                      sample;

  // START samples after half a bit so every later sample lands mid-bit.
  assign sample = (state_q == ST_START) ? (clk_cnt_q == HALF_M1) : (clk_cnt_q == FULL_M1);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (sample) clk_cnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (rxs != UART_IDLE_LEVEL) state_d = ST_START;
      end
      ST_START: begin
        if (sample) begin
          if (rxs == UART_IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_d[bit_idx_q] = rxs;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          par_bad_d = (rxs != (^shreg_q));
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // A low stop bit wins over a parity mismatch and parks us until the line idles.
        if (sample) begin
          if (rxs != UART_IDLE_LEVEL) begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end
`endif
          else begin
            ready_d = 1'b1;
            data_d  = shreg_q;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rxs == UART_IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_if.rx_data      = data_q;
  assign rx_if.rx_ready     = ready_q;
  assign rx_if.rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.rx_parity_err = perr_q;
`else
  assign rx_if.rx_parity_err = 1'b0;
`endif
  assign rx_if.rx_busy      = (state_q != ST_IDLE);
  assign rx_if.rx_state     = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (10 + P) * N;
  // pin low at cycle t -> strobe visible at t + 2 + H + (9+P)*N + 1
  localparam int SOFS  = 2 + N / 2 + (9 + P) * N + 1;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy_cnt = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;
  int   t;

  logic [7:0] exp_q[$];
  int         exp_t[$];

  uart_rx_byte_if rx_if ();

  uart_rx_byte #(
    .CLK_FREQ     (N * 9600),
    .BAUD         (9600),
    .CLKS_PER_BIT (N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // driver tasks (called and returning on a negedge)
  task automatic at_cycle(input int tc);
    if (cyc > tc) check("schedule", cyc, tc);
    while (cyc < tc) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_if.rxd = 1'b0;
    idle(N);
    for (int i = 0; i < 8; i++) begin
      rx_if.rxd = d[i];
      idle(N);
    end
`ifdef UART_RX_PARITY_EN
    rx_if.rxd = ^d;
    idle(N);
`endif
    rx_if.rxd = stop;
    idle(N);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_bad_par(input logic [7:0] d);
    rx_if.rxd = 1'b0;
    idle(N);
    for (int i = 0; i < 8; i++) begin
      rx_if.rxd = d[i];
      idle(N);
    end
    rx_if.rxd = ~(^d);
    idle(N);
    rx_if.rxd = 1'b1;
    idle(N);
  endtask
`endif

  task automatic expect_byte(input logic [7:0] d, input int tc);
    exp_q.push_back(d);
    exp_t.push_back(tc);
  endtask

  // scoreboard / protocol monitor
  logic       rst_seen = 1'b1;
  logic       prev_ready = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (rx_if.rx_ready === 1'b1) begin
      rdy_cnt++;
      check("ready_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("rx_data", rx_if.rx_data, exp_q.pop_front());
        check("ready_time", cyc, exp_t.pop_front());
      end
    end
    if (rx_if.rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_if.rx_parity_err === 1'b1) perr_cnt++;
    if ((rx_if.rx_ready | rx_if.rx_frame_err | rx_if.rx_parity_err) === 1'b1)
      check("strobe_onehot",
            32'(rx_if.rx_ready) + 32'(rx_if.rx_frame_err) + 32'(rx_if.rx_parity_err), 32'd1);
    if (prev_ready) check("ready_width", rx_if.rx_ready, 1'b0);
    if (prev_ferr)  check("ferr_width", rx_if.rx_frame_err, 1'b0);
    if (rst_seen === 1'b0 && rx_if.rx_data !== prev_data)
      check("data_change_with_ready", rx_if.rx_ready, 1'b1);
    prev_ready = rx_if.rx_ready;
    prev_ferr  = rx_if.rx_frame_err;
    prev_data  = rx_if.rx_data;
  end

  // directed stimulus
  initial begin
    rst       = 1'b1;
    rx_if.rxd = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(1);

    check("rst_data",   rx_if.rx_data, 8'h00);
    check("rst_ready",  rx_if.rx_ready, 1'b0);
    check("rst_ferr",   rx_if.rx_frame_err, 1'b0);
    check("rst_perr",   rx_if.rx_parity_err, 1'b0);
    check("rst_busy",   rx_if.rx_busy, 1'b0);
    check("rst_state",  rx_if.rx_state, ST_IDLE);
    idle(10);

    // single frame 0xA5 with busy/strobe timing
    t = cyc;
    expect_byte(8'hA5, t + SOFS);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        at_cycle(t + 2);        check("a5_busy_t0", rx_if.rx_busy, 1'b0);
        at_cycle(t + 3);        check("a5_busy_t1", rx_if.rx_busy, 1'b1);
                                check("a5_state_t1", rx_if.rx_state, ST_START);
        at_cycle(t + SOFS - 1); check("a5_busy_last", rx_if.rx_busy, 1'b1);
                                check("a5_ready_early", rx_if.rx_ready, 1'b0);
        at_cycle(t + SOFS);     check("a5_ready", rx_if.rx_ready, 1'b1);
                                check("a5_busy_done", rx_if.rx_busy, 1'b0);
                                check("a5_data", rx_if.rx_data, 8'hA5);
        at_cycle(t + SOFS + 1); check("a5_ready_off", rx_if.rx_ready, 1'b0);
      end
    join
    idle(7);

    // back-to-back 0x00, 0xFF
    t = cyc;
    expect_byte(8'h00, t + SOFS);
    expect_byte(8'hFF, t + FRAME + SOFS);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(5);
    check("b2b_data", rx_if.rx_data, 8'hFF);
    check("b2b_count", rdy_cnt, 3);

    // 4-cycle glitch
    t = cyc;
    rx_if.rxd = 1'b0;
    idle(4);
    rx_if.rxd = 1'b1;
    at_cycle(t + 10); check("glitch_in_start", rx_if.rx_state, ST_START);
    at_cycle(t + 11); check("glitch_idle", rx_if.rx_state, ST_IDLE);
                      check("glitch_busy", rx_if.rx_busy, 1'b0);
    idle(20);
    check("glitch_data", rx_if.rx_data, 8'hFF);
    check("glitch_count", rdy_cnt, 3);

    // good 0x11, then 0x3C with low stop held low, then 0x5A
    t = cyc;
    expect_byte(8'h11, t + SOFS);
    send_frame(8'h11, 1'b1);
    idle(4);
    t = cyc;
    fork
      begin
        send_frame(8'h3C, 1'b0);
        idle(40);
        rx_if.rxd = 1'b1;
      end
      begin
        at_cycle(t + SOFS);       check("fe_pulse", rx_if.rx_frame_err, 1'b1);
                                  check("fe_no_ready", rx_if.rx_ready, 1'b0);
                                  check("fe_data_held", rx_if.rx_data, 8'h11);
        at_cycle(t + FRAME + 38); check("fe_wait_high", rx_if.rx_state, ST_WAIT_HIGH);
                                  check("fe_busy", rx_if.rx_busy, 1'b1);
      end
    join
    at_cycle(t + FRAME + 44);
    check("fe_back_idle", rx_if.rx_state, ST_IDLE);
    t = cyc;
    expect_byte(8'h5A, t + SOFS);
    send_frame(8'h5A, 1'b1);
    idle(4);
    check("fe_count", ferr_cnt, 1);
    check("after_fe_data", rx_if.rx_data, 8'h5A);

    // reset during data bit 4 of 0x7E
    t = cyc;
    rx_if.rxd = 1'b0;
    idle(N);
    for (int i = 0; i < 4; i++) begin
      rx_if.rxd = 8'h7E >> i;
      idle(N);
    end
    rx_if.rxd = 1'b1;
    idle(N / 2);
    check("mid_busy", rx_if.rx_busy, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_data",  rx_if.rx_data, 8'h00);
    check("mid_rst_busy",  rx_if.rx_busy, 1'b0);
    check("mid_rst_ready", rx_if.rx_ready, 1'b0);
    check("mid_rst_state", rx_if.rx_state, ST_IDLE);
    idle(3 * N);
    check("mid_rst_quiet", rdy_cnt, 5);
    t = cyc;
    expect_byte(8'h81, t + SOFS);
    send_frame(8'h81, 1'b1);
    idle(4);
    check("after_rst_data", rx_if.rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    t = cyc;
    fork
      send_frame_bad_par(8'h07);
      begin
        at_cycle(t + SOFS); check("par_err_pulse", rx_if.rx_parity_err, 1'b1);
                            check("par_no_ready", rx_if.rx_ready, 1'b0);
                            check("par_data_held", rx_if.rx_data, 8'h81);
      end
    join
    idle(4);
    t = cyc;
    expect_byte(8'h07, t + SOFS);
    send_frame(8'h07, 1'b1);
    idle(4);
    check("par_good_data", rx_if.rx_data, 8'h07);
    check("perr_count", perr_cnt, 1);
    check("total_ready", rdy_cnt, 7);
`else
    check("perr_count", perr_cnt, 0);
    check("total_ready", rdy_cnt, 6);
`endif
    check("scoreboard_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
